imem_loader_ctrl: RTL
=====================

Name: imem_loader_ctrl

Overview:
Boot and run controller for the single-cycle core's instruction memory. It holds the core halted and accepts a program as a stream of 32-bit words over a valid/ready handshake. It writes those words sequentially into the instruction-memory write port and zero-fills the unused words, so they execute as 0. It then releases the core and, while the core runs, maps the fetch PC onto the memory read address and flags illegal fetches.

Parameters:
DEPTH, 64, number of 32-bit instruction words in the memory
ADDR_W, 6, word-address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock, asynchronous, active-low
start  in  1  single-cycle pulse; begins a load, honoured only in IDLE
load_count  in  ADDR_W+1  number of words to load, sampled with start
stop  in  1  single-cycle pulse; halts the core, honoured only in RUN
in_valid  in  1  loader stream word valid
in_data  in  32  loader stream word
in_ready  out  1  controller accepts a word; asserted only in LOAD
mem_we  out  1  instruction-memory write enable
mem_waddr  out  ADDR_W  instruction-memory word write address
mem_wdata  out  32  instruction-memory write data
pc  in  32  core fetch byte address
mem_raddr  out  ADDR_W  instruction-memory word read address, equal to pc[ADDR_W+1:2]
cpu_run  out  1  core enable; 0 means the core is stalled
load_done  out  1  memory image complete
fetch_fault  out  1  sticky illegal-fetch flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_run=0, load_done=0, fetch_fault=0, word counter=0. Memory contents are not cleared.
- Reset asserted mid-LOAD or mid-FILL aborts immediately. The memory image is undefined until the next complete load.
- States: IDLE, LOAD, FILL, RUN.
- IDLE:
  - start=1 latches N = min(load_count, DEPTH) and clears the counter and fetch_fault.
  - If N>0, go to LOAD; if N=0, go to FILL.
- LOAD:
  - in_ready=1 (decoded from state).
  - A word is accepted on each edge where in_valid & in_ready.
  - At that edge, mem_we/mem_waddr/mem_wdata are registered as 1/counter/in_data, and the counter increments.
  - Write latency is one cycle after the handshake.
  - On acceptance of word N-1: go to FILL if N<DEPTH, else go to RUN.
  - In LOAD, mem_we=0 in any cycle not following a handshake.
- FILL:
  - in_ready=0.
  - Each edge registers mem_we=1, mem_waddr=counter, mem_wdata=0, and increments the counter.
  - After the write to address DEPTH-1 is registered, go to RUN.
- RUN:
  - cpu_run=1 and load_done=1, both registered.
  - The first RUN cycle follows the last write cycle, so mem_we and cpu_run are never high together.
  - mem_we=0 and in_ready=0.
  - mem_raddr is combinational from pc in all states.
- fetch_fault:
  - Set at an edge in RUN when pc[1:0]!=0 or pc >= DEPTH*4.
  - Stays high until reset or the next accepted start.
  - The faulting fetch still sees the truncated address; the core is not stopped.
- stop in RUN: go to IDLE. cpu_run=0 and load_done=0 from the next cycle; memory is retained.
- Ignored inputs: start outside IDLE, stop outside RUN, in_valid outside LOAD.
- Simultaneous start and stop in RUN: stop wins and start is ignored.
- Counter wrap: the counter is ADDR_W+1 bits and never exceeds DEPTH. Addresses DEPTH-1 to 0 never wrap within one load.

Decomposition:
- Package imem_pkg holds:
  - the state enum {IDLE, LOAD, FILL, RUN};
  - IMEM_DEPTH=64 and IMEM_ADDR_W=6;
  - the zero-instruction constant (32'd0).
- One natural sub-module, fetch_addr_check: combinational. It takes pc and DEPTH and produces the word address and an illegal flag.
- The write-port-capable instruction memory is instantiated at top level, outside this block.

Test Plan:
- Reset/idle: rst_n low mid-cycle -> all outputs 0 asynchronously; after release, in_ready=0 and cpu_run=0 with no stimulus.
- Partial load: start with load_count=4 and words 0xFFC4A303, 0x0064A623, 0x0062E233, 0xFE420AE3, with in_valid toggling every other cycle:
  - writes land at addresses 0..3 one cycle after each handshake;
  - then 60 contiguous zero writes to addresses 4..63;
  - then cpu_run=1 the cycle after the write to address 63.
- Full and clamped load:
  - load_count=64 -> no FILL, RUN right after the 64th write.
  - load_count=100 -> clamped to 64, identical behaviour.
  - load_count=0 -> 64 zero writes, then RUN.
- Fetch mapping and faults in RUN:
  - pc=0x10 -> mem_raddr=4, fault 0.
  - pc=0x12 -> fetch_fault=1 and stays 1.
  - pc=0x100 -> fetch_fault=1.
  - A new start clears fetch_fault.
- Control corner cases:
  - start during LOAD ignored (counter unchanged).
  - start+stop together in RUN -> IDLE with cpu_run=0 next cycle.
  - rst_n low during FILL -> IDLE, mem_we=0 immediately.

Source files
------------

// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory boot/run controller.
//   state_e          : controller FSM states
//   IMEM_DEPTH       : instruction words in the memory
//   IMEM_ADDR_W      : word-address width, log2(IMEM_DEPTH)
//   IMEM_ZERO_INSTR  : word written into every unloaded location
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int unsigned IMEM_DEPTH  = 64;
    localparam int unsigned IMEM_ADDR_W = 6;

    localparam logic [31:0] IMEM_ZERO_INSTR = 32'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_loader_ctrl_if
// Bundles the program-word stream and the instruction-memory write port.
//   in_valid / in_data : stream word offered by the loader source
//   in_ready           : controller accepts the offered word
//   mem_we / mem_waddr / mem_wdata : instruction-memory write port
// Modports:
//   slave  : the controller (consumes the stream, drives the write port)
//   master : the stream source / memory side
// ----------------------------------------------------------------------------
interface imem_loader_ctrl_if
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) ();

    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

endinterface

// File: rtl/fetch_addr_check.sv
// ----------------------------------------------------------------------------
// fetch_addr_check
// Combinational map of the core's byte fetch address onto a word address,
// plus a flag for fetches that are misaligned or beyond the memory.
//   i_pc        : core fetch byte address
//   o_word_addr : word address, i_pc[ADDR_W+1:2] (truncated, never blocked)
//   o_illegal   : i_pc[1:0] != 0 or i_pc >= DEPTH*4
// ----------------------------------------------------------------------------
module fetch_addr_check
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic [31:0]       i_pc,
    output logic [ADDR_W-1:0] o_word_addr,
    output logic              o_illegal
);

    localparam logic [31:0] LP_BYTE_LIMIT = 32'(DEPTH) << 2;

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (i_pc[1:0] != 2'b00);
    assign w_out_of_range = (i_pc >= LP_BYTE_LIMIT);

    assign o_word_addr = i_pc[ADDR_W+1:2];
    assign o_illegal   = w_misaligned | w_out_of_range;

endmodule

// File: rtl/imem_loader_ctrl.sv
// ----------------------------------------------------------------------------
// imem_loader_ctrl
// Boot and run controller for the instruction memory. Holds the core halted,
// streams a program into memory, zero-fills the remainder, then releases the
// core and watches its fetch addresses.
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   i_start        : begin a load (IDLE only), samples i_load_count
//   i_load_count   : words to load, clamped to DEPTH
//   i_stop         : halt the core and return to IDLE (RUN only)
//   i_pc           : core fetch byte address
//   o_mem_raddr    : memory read word address, combinational from i_pc
//   o_cpu_run      : core enable
//   o_load_done    : memory image complete
//   o_fetch_fault  : sticky illegal-fetch flag
//   bus            : stream in / memory write port (slave side)
// ----------------------------------------------------------------------------
module imem_loader_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [ADDR_W:0]     i_load_count,
    input  logic                i_stop,
    input  logic [31:0]         i_pc,
    output logic [ADDR_W-1:0]   o_mem_raddr,
    output logic                o_cpu_run,
    output logic                o_load_done,
    output logic                o_fetch_fault,
    imem_loader_ctrl_if.slave   bus
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    state_e            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_n;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_run;
    logic              r_fault;

    state_e            w_state_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W:0]   w_n_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_run_nxt;
    logic              w_fault_nxt;

    logic [ADDR_W:0]   w_n_clamp;
    logic              w_in_ready;
    logic              w_hs;
    logic              w_illegal;

    fetch_addr_check #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fetch_addr_check (
        .i_pc        (i_pc),
        .o_word_addr (o_mem_raddr),
        .o_illegal   (w_illegal)
    );

    assign w_n_clamp  = (i_load_count > LP_DEPTH) ? LP_DEPTH : i_load_count;
    assign w_in_ready = (r_state == LOAD);
    assign w_hs       = bus.in_valid & w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_fault_nxt = r_fault;

        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_n_nxt     = w_n_clamp;
                    w_cnt_nxt   = '0;
                    w_fault_nxt = 1'b0;
                    w_state_nxt = (w_n_clamp == '0) ? FILL : LOAD;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_cnt[ADDR_W-1:0];
                    w_wdata_nxt = bus.in_data;
                    w_cnt_nxt   = r_cnt + LP_ONE;
                    // r_n is nonzero here: a zero count goes straight to FILL.
                    if (r_cnt == r_n - LP_ONE) begin
                        w_state_nxt = (r_n < LP_DEPTH) ? FILL : RUN;
                    end
                end
            end
            FILL: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_cnt[ADDR_W-1:0];
                w_wdata_nxt = IMEM_ZERO_INSTR;
                w_cnt_nxt   = r_cnt + LP_ONE;
                if (r_cnt == LP_DEPTH - LP_ONE) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_illegal) begin
                    w_fault_nxt = 1'b1;
                end
                // stop takes priority; start is never looked at outside IDLE.
                if (i_stop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Enable only once RUN has been held for a full cycle, so the core is
        // released the cycle after the final memory write.
        w_run_nxt = (r_state == RUN) && (w_state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_run   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_run   <= w_run_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_waddr = r_waddr;
    assign bus.mem_wdata = r_wdata;

    assign o_cpu_run     = r_run;
    assign o_load_done   = r_run;
    assign o_fetch_fault = r_fault;

endmodule
